proj_kmer_window: RTL and testbench
===================================

# proj_kmer_window

Streaming k-mer window generator for the MinHash front end: it accepts one nucleotide per handshake, maintains a sliding window of the last KMER_LEN bases and emits one k-mer per accepted base once the window is full. It sits between the sequence reader and the hash units. Beyond a plain shift buffer, it adds:
- valid/ready flow control on both sides
- ambiguous-base (N) window restart
- sequence-position tagging
- end-of-sequence handling
- optional canonical (strand-independent) k-mer output

## Interface
Parameters:
- BASE_BITS, 2, bits per nucleotide (A=00, C=01, G=10, T=11)
- KMER_LEN, 16, bases per k-mer (≥2)
- POS_WIDTH, 32, width of the sequence position counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start_over  in  1  synchronous flush of window, counters and output register
- in_valid  in  1  input base valid
- in_ready  out  1  block can accept a base
- in_base  in  BASE_BITS  nucleotide code
- in_amb  in  1  base is ambiguous (N); in_base is ignored
- in_last  in  1  base is the final base of the current sequence
- out_valid  out  1  k-mer available
- out_ready  in  1  downstream accepts k-mer
- out_kmer  out  KMER_LEN*BASE_BITS  k-mer; newest base in bits [BASE_BITS-1:0], oldest base in the MSBs
- out_pos  out  POS_WIDTH  sequence index of the k-mer's oldest (first) base
- out_last  out  1  k-mer was produced by the in_last base
- out_strand  out  1  canonical orientation: 1 = reverse complement chosen
- fill  out  $clog2(KMER_LEN+1)  bases currently held in the window

## Operation
- Accept: `in_valid && in_ready`.
- in_ready is `!start_over && (!out_valid || out_ready)`. It is combinational and derives from the output register only.
- On accept of a non-ambiguous base:
  - The window shifts one position toward the MSBs, and in_base enters at the LSBs.
  - `fill = min(fill+1, KMER_LEN)`.
  - pos (the index of this base) is incremented after use.
- On accept with in_amb = 1:
  - Window is cleared to 0 and fill is set to 0.
  - pos still increments, since N occupies a sequence position.
  - No k-mer is emitted.
- Emit: a non-ambiguous accepted base whose updated fill equals KMER_LEN loads the output register with:
  - `out_kmer` = the new window
  - `out_pos = pos − (KMER_LEN−1)`
  - `out_last = in_last`
  - out_valid is set.
- Window state:
  - FILLING: fill < KMER_LEN.
  - STREAMING: fill == KMER_LEN.
  - FILLING → STREAMING on the accept that reaches KMER_LEN.
  - Any state → FILLING (fill = 0) on in_amb, on an in_last accept, or on start_over.
- in_last accept:
  - That base is processed normally (it may emit, with out_last = 1).
  - Then window, fill and pos reset to 0 for the next sequence.
  - If in_last arrives while fill < KMER_LEN−1, nothing is emitted.
  - An in_amb base with in_last = 1 emits nothing and resets.
- Output register:
  - Cleared when `out_valid && out_ready` and no new emit occurs in the same cycle.
  - A simultaneous consume and emit reloads the register, sustaining 1 k-mer/cycle.
- pos wraps modulo 2^POS_WIDTH. out_pos subtraction is also modulo 2^POS_WIDTH.
- start_over:
  - Has priority over everything else.
  - Clears window, fill, pos, out_valid and out_last.
  - Any base presented in that cycle is not accepted.

## Timing
- Reset values: out_valid = 0, out_kmer = 0, out_pos = 0, out_last = 0, out_strand = 0, fill = 0. in_ready = 1 once rst_n deasserts, if start_over = 0.
- Latency: the k-mer appears on out_valid 1 cycle after the accept of its newest base.
- Throughput: 1 base and 1 k-mer per cycle under continuous valid/ready.
- Stability: out_kmer, out_pos, out_last and out_strand are held stable while `out_valid && !out_ready`.
- Reset mid-stream: all state is lost. The first k-mer after reset needs KMER_LEN fresh accepts.

## Configuration
- Macro: PROJ_KMER_CANONICAL_EN.
- When defined:
  - A reverse-complement window is maintained in parallel. On each accept, `~in_base` enters at the MSB position and the window shifts toward the LSBs.
  - It is cleared under the same conditions as the forward window.
  - out_kmer is min(forward, revcomp), compared as unsigned. out_strand = 1 only when revcomp < forward; ties give out_strand = 0.
  - Requires BASE_BITS == 2; any other value is an elaboration error.
- When not defined:
  - out_kmer is the forward window.
  - out_strand is tied to 0.
  - No revcomp register exists.

## Test plan
All cases use BASE_BITS = 2 and KMER_LEN = 4.
- Basic: A,C,G,T back-to-back, out_ready = 1 → one output, out_kmer = 0x1B, out_pos = 0, out_valid 1 cycle after the T accept; one more base A → 0x6C, out_pos = 1.
- Ambiguous: A,C,N,G,T,A,C → single output 0xB1 (GTAC), out_pos = 3; no output before the final C.
- Backpressure: out_ready = 0 after the first k-mer → in_ready = 0, out_kmer held at 0x1B for 10 cycles; releasing out_ready resumes 1 k-mer/cycle with no base lost.
- End of sequence: A,C,G,T(in_last) then A,A,A,A → 0x1B with out_last = 1, then 0x00 with out_pos = 0; a short sequence A,C(in_last) emits nothing.
- start_over: start_over pulsed after 3 bases with in_valid = 1 → fill = 0, that base not accepted; the next 4 bases produce out_pos = 0.
- Canonical (macro on): T,T,T,T → out_kmer = 0x00, out_strand = 1; A,C,G,T → 0x1B, out_strand = 0.

Source files
------------

// File: rtl/proj_kmer_window.sv
// Streaming k-mer window: one base in, one k-mer out per accepted base once the window is full.
// Optional canonical (min of forward / reverse-complement) output under PROJ_KMER_CANONICAL_EN.
module proj_kmer_window #(
   parameter int BASE_BITS = 2,
   parameter int KMER_LEN  = 16,
   parameter int POS_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start_over,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [BASE_BITS-1:0]              in_base,
   input  logic                              in_amb,
   input  logic                              in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [KMER_LEN*BASE_BITS-1:0]     out_kmer,
   output logic [POS_WIDTH-1:0]              out_pos,
   output logic                              out_last,
   output logic                              out_strand,
   output logic [$clog2(KMER_LEN+1)-1:0]     fill
);

   localparam int KW     = KMER_LEN * BASE_BITS;
   localparam int FILL_W = $clog2(KMER_LEN + 1);
   localparam logic [FILL_W-1:0]    FULL = FILL_W'(KMER_LEN);
   localparam logic [POS_WIDTH-1:0] BACK = POS_WIDTH'(KMER_LEN - 1);

   typedef enum logic [0:0] {
      ST_FILLING   = 1'b0,
      ST_STREAMING = 1'b1
   } win_state_e;

   win_state_e           st_q, st_d;
   logic [KW-1:0]        win_q, win_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [POS_WIDTH-1:0] pos_q, pos_d;
   logic                 ov_q, ov_d;
   logic [KW-1:0]        okmer_q, okmer_d;
   logic [POS_WIDTH-1:0] opos_q, opos_d;
   logic                 olast_q, olast_d;

   logic                 accept;
   logic                 emit;
   logic [KW-1:0]        win_shift;
   logic [FILL_W-1:0]    fill_inc;
   logic [KW-1:0]        kmer_sel;
   logic                 strand_sel;

   assign in_ready  = !start_over && (!ov_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign win_shift = {win_q[KW-BASE_BITS-1:0], in_base};
   assign emit      = accept && !in_amb && (fill_inc == FULL);

   // Fill saturates once the window is streaming.
   always_comb begin
      fill_inc = fill_q;
      case (st_q)
         ST_STREAMING: fill_inc = FULL;
         ST_FILLING:   fill_inc = fill_q + FILL_W'(1);
         default:      fill_inc = FULL;
      endcase
   end

`ifdef PROJ_KMER_CANONICAL_EN
   if (BASE_BITS != 2) begin : g_base_bits_chk
      $error("proj_kmer_window: canonical mode needs BASE_BITS == 2");
   end

   logic [KW-1:0] rc_q, rc_d;
   logic [KW-1:0] rc_shift;
   logic          ostrand_q, ostrand_d;
   logic          rc_lt;

   // Reverse complement: complemented base enters at the MSBs and slides toward the LSBs.
   assign rc_shift   = {~in_base, rc_q[KW-1:BASE_BITS]};
   assign rc_lt      = (rc_shift < win_shift);
   assign kmer_sel   = rc_lt ? rc_shift : win_shift;
   assign strand_sel = rc_lt;
   assign out_strand = ostrand_q;

   // Reverse-complement window and strand flag follow the forward window's clear rules.
   always_comb begin
      rc_d      = rc_q;
      ostrand_d = ostrand_q;
      if (start_over) begin
         rc_d      = '0;
         ostrand_d = 1'b0;
      end else if (accept) begin
         if (in_amb || in_last) begin
            rc_d = '0;
         end else begin
            rc_d = rc_shift;
         end
         if (emit) begin
            ostrand_d = strand_sel;
         end else begin
            ostrand_d = ostrand_q;
         end
      end else begin
         rc_d = rc_q;
      end
   end

   // Reverse-complement state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc_q      <= '0;
         ostrand_q <= 1'b0;
      end else begin
         rc_q      <= rc_d;
         ostrand_q <= ostrand_d;
      end
   end
`else
   assign kmer_sel   = win_shift;
   assign strand_sel = 1'b0;
   assign out_strand = strand_sel;
`endif

   // Next state: start_over first, then output consume, then the accepted base.
   always_comb begin
      st_d    = st_q;
      win_d   = win_q;
      fill_d  = fill_q;
      pos_d   = pos_q;
      ov_d    = ov_q;
      okmer_d = okmer_q;
      opos_d  = opos_q;
      olast_d = olast_q;
      if (start_over) begin
         st_d    = ST_FILLING;
         win_d   = '0;
         fill_d  = '0;
         pos_d   = '0;
         ov_d    = 1'b0;
         okmer_d = '0;
         opos_d  = '0;
         olast_d = 1'b0;
      end else begin
         if (ov_q && out_ready) begin
            ov_d = 1'b0;
         end else begin
            ov_d = ov_q;
         end
         if (accept) begin
            pos_d = pos_q + POS_WIDTH'(1);
            if (in_amb) begin
               win_d  = '0;
               fill_d = '0;
               st_d   = ST_FILLING;
            end else begin
               win_d  = win_shift;
               fill_d = fill_inc;
               st_d   = (fill_inc == FULL) ? ST_STREAMING : ST_FILLING;
            end
            if (emit) begin
               ov_d    = 1'b1;
               okmer_d = kmer_sel;
               opos_d  = pos_q - BACK;
               olast_d = in_last;
            end else begin
               okmer_d = okmer_q;
            end
            // The last base of a sequence still emits above, then the next sequence starts clean.
            if (in_last) begin
               win_d  = '0;
               fill_d = '0;
               pos_d  = '0;
               st_d   = ST_FILLING;
            end else begin
               pos_d = pos_d;
            end
         end else begin
            pos_d = pos_q;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= ST_FILLING;
         win_q   <= '0;
         fill_q  <= '0;
         pos_q   <= '0;
         ov_q    <= 1'b0;
         okmer_q <= '0;
         opos_q  <= '0;
         olast_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         win_q   <= win_d;
         fill_q  <= fill_d;
         pos_q   <= pos_d;
         ov_q    <= ov_d;
         okmer_q <= okmer_d;
         opos_q  <= opos_d;
         olast_q <= olast_d;
      end
   end

   assign out_valid = ov_q;
   assign out_kmer  = okmer_q;
   assign out_pos   = opos_q;
   assign out_last  = olast_q;
   assign fill      = fill_q;

endmodule

// File: tb/tb_proj_kmer_window.sv
// Bench for proj_kmer_window (KMER_LEN=4): queue-based reference model checked every cycle,
// plus directed sequences with hand-computed k-mers.
module tb_proj_kmer_window;
   localparam int BB = 2;
   localparam int K  = 4;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst_n, start_over, in_valid, in_ready, in_amb, in_last;
   logic [BB-1:0] in_base;
   logic          out_valid, out_ready, out_last, out_strand;
   logic [K*BB-1:0] out_kmer;
   logic [PW-1:0] out_pos;
   logic [2:0]    fill;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  kmer;
      logic [31:0] pos;
      logic        last;
      logic        strand;
   } exp_t;

   exp_t        exp_q[$];
   int          win_m[$];
   logic [31:0] pos_m = 32'd0;

   always #5 clk = ~clk;

   proj_kmer_window #(.BASE_BITS(BB), .KMER_LEN(K), .POS_WIDTH(PW)) dut (
      .clk(clk), .rst_n(rst_n), .start_over(start_over),
      .in_valid(in_valid), .in_ready(in_ready), .in_base(in_base),
      .in_amb(in_amb), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_kmer(out_kmer),
      .out_pos(out_pos), .out_last(out_last), .out_strand(out_strand),
      .fill(fill)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference: the window is a list of bases; a k-mer is emitted whenever it holds K of them.
   task automatic model_base(input int b, input logic amb, input logic last);
      exp_t e;
      int   fw, rc;
      if (amb) begin
         win_m.delete();
      end else begin
         win_m.push_back(b);
         if (win_m.size() > K) void'(win_m.pop_front());
         if (win_m.size() == K) begin
            fw = 0;
            rc = 0;
            for (int i = 0; i < K; i++) fw = (fw << 2) | win_m[i];
            for (int j = 0; j < K; j++) rc = (rc << 2) | (3 - win_m[K-1-j]);
`ifdef PROJ_KMER_CANONICAL_EN
            e.strand = (rc < fw);
            e.kmer   = (rc < fw) ? rc[7:0] : fw[7:0];
`else
            e.strand = 1'b0;
            e.kmer   = fw[7:0];
`endif
            e.pos  = pos_m - 32'(K - 1);
            e.last = last;
            exp_q.push_back(e);
         end
      end
      pos_m = pos_m + 32'd1;
      if (last) begin
         win_m.delete();
         pos_m = 32'd0;
      end
   endtask

   initial begin
      logic consume, acc;
      forever begin
         @(posedge clk);
         if (!rst_n || start_over) begin
            exp_q.delete();
            win_m.delete();
            pos_m = 32'd0;
         end else begin
            consume = (exp_q.size() != 0) && out_ready;
            acc     = in_valid && ((exp_q.size() == 0) || out_ready);
            if (consume) void'(exp_q.pop_front());
            if (acc) model_base(int'(in_base), in_amb, in_last);
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("in_ready", in_ready, !start_over && ((exp_q.size() == 0) || out_ready));
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("fill", fill, win_m.size());
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               chk("out_kmer", out_kmer, e.kmer);
               chk("out_pos", out_pos, e.pos);
               chk("out_last", out_last, e.last);
               chk("out_strand", out_strand, e.strand);
            end
         end
      end
   end

   task automatic send(input logic [1:0] b, input logic amb, input logic last);
      logic ok;
      int   n;
      n = 0;
      in_valid = 1'b1;
      in_base  = b;
      in_amb   = amb;
      in_last  = last;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 50);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
      end
      in_valid = 1'b0;
      in_amb   = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic flush();
      start_over = 1'b1;
      @(posedge clk);
      #1;
      start_over = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start_over = 1'b0; in_valid = 1'b0; in_base = 2'd0;
      in_amb = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_kmer", out_kmer, 8'h00);
      chk("rst_out_pos", out_pos, 32'd0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_strand", out_strand, 1'b0);
      chk("rst_fill", fill, 3'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Basic: ACGT -> 0x1B, then A -> CGTA 0x6C
      send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0);
      chk("basic_none_yet", out_valid, 1'b0);
      send(2'd3, 1'b0, 1'b0);
      chk("basic_valid", out_valid, 1'b1);
      chk("basic_kmer", out_kmer, 8'h1B);
      chk("basic_pos", out_pos, 32'd0);
      send(2'd0, 1'b0, 1'b0);
      chk("basic2_kmer", out_kmer, 8'h6C);
      chk("basic2_pos", out_pos, 32'd1);

      // Ambiguous: A,C,N,G,T,A,C -> GTAC 0xB1 at pos 3
      flush();
      send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0); send(2'd3, 1'b1, 1'b0);
      chk("amb_fill", fill, 3'd0);
      send(2'd2, 1'b0, 1'b0); send(2'd3, 1'b0, 1'b0); send(2'd0, 1'b0, 1'b0);
      chk("amb_none_yet", out_valid, 1'b0);
      send(2'd1, 1'b0, 1'b0);
      chk("amb_kmer", out_kmer, 8'hB1);
      chk("amb_pos", out_pos, 32'd3);

      // Backpressure: hold 0x1B for 10 cycles, then G,A,C stream out back-to-back
      flush();
      send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0);
      send(2'd3, 1'b0, 1'b0);
      out_ready = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("bp_hold_kmer", out_kmer, 8'h1B);
         chk("bp_in_ready", in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(2'd2, 1'b0, 1'b0);
      chk("bp_kmer1", out_kmer, 8'h6E);
      send(2'd0, 1'b0, 1'b0);
      chk("bp_kmer2", out_kmer, 8'hB8);
      send(2'd1, 1'b0, 1'b0);
      chk("bp_kmer3", out_kmer, 8'hE1);
      chk("bp_pos3", out_pos, 32'd3);

      // End of sequence: ACGT(last) then AAAA
      flush();
      send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0);
      send(2'd3, 1'b0, 1'b1);
      chk("eos_kmer", out_kmer, 8'h1B);
      chk("eos_last", out_last, 1'b1);
      chk("eos_fill", fill, 3'd0);
      repeat (4) send(2'd0, 1'b0, 1'b0);
      chk("eos_next_kmer", out_kmer, 8'h00);
      chk("eos_next_pos", out_pos, 32'd0);
      chk("eos_next_last", out_last, 1'b0);
      flush();
      send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b1);
      chk("short_none", out_valid, 1'b0);
      chk("short_fill", fill, 3'd0);
      send(2'd0, 1'b1, 1'b1);
      chk("amb_last_none", out_valid, 1'b0);

      // start_over with a base presented: base dropped, next four give pos 0
      flush();
      send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0);
      start_over = 1'b1; in_valid = 1'b1; in_base = 2'd3;
      @(negedge clk);
      chk("so_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      start_over = 1'b0; in_valid = 1'b0;
      chk("so_fill", fill, 3'd0);
      send(2'd3, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0);
      send(2'd0, 1'b0, 1'b0);
      chk("so_kmer", out_kmer, 8'hE4);
      chk("so_pos", out_pos, 32'd0);

      // Canonical selection: TTTT and ACGT
      flush();
      repeat (4) send(2'd3, 1'b0, 1'b0);
`ifdef PROJ_KMER_CANONICAL_EN
      chk("canon_tttt_kmer", out_kmer, 8'h00);
      chk("canon_tttt_strand", out_strand, 1'b1);
`else
      chk("fwd_tttt_kmer", out_kmer, 8'hFF);
      chk("fwd_tttt_strand", out_strand, 1'b0);
`endif
      flush();
      send(2'd0, 1'b0, 1'b0); send(2'd1, 1'b0, 1'b0); send(2'd2, 1'b0, 1'b0);
      send(2'd3, 1'b0, 1'b0);
      chk("canon_acgt_kmer", out_kmer, 8'h1B);
      chk("canon_acgt_strand", out_strand, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
